stack_pointer_unit: RTL

//   Parametrised stack-pointer register for the CPU datapath, driven by the decode stage's op code.

---
 rtl/stack_pointer_unit_pkg.sv | 22 ++
 rtl/stack_pointer_unit_if.sv | 24 ++
 rtl/stack_pointer_unit_guard.sv | 51 +++++
 rtl/stack_pointer_unit.sv | 109 ++++++++++
 4 files changed

// File: rtl/stack_pointer_unit_pkg.sv
// Shared op codes and fault codes for the stack pointer unit.
package sp_pkg;

    typedef logic [3:0] sp_op_t;
    typedef logic [1:0] fault_code_t;

    // Op codes issued by the decode stage; anything else is a NOP.
    localparam sp_op_t SP_NOP     = 4'd0;
    localparam sp_op_t SP_LOAD    = 4'd1;
    localparam sp_op_t SP_PUSH    = 4'd2;
    localparam sp_op_t SP_POP     = 4'd3;
    localparam sp_op_t SP_ADJ     = 4'd4;
    localparam sp_op_t SP_SAVE    = 4'd5;
    localparam sp_op_t SP_RESTORE = 4'd6;

    // Fault codes reported on fault_code.
    localparam fault_code_t FC_NONE  = 2'b00;
    localparam fault_code_t FC_OVF   = 2'b01;
    localparam fault_code_t FC_UNF   = 2'b10;
    localparam fault_code_t FC_RANGE = 2'b11;

endpackage

// File: rtl/stack_pointer_unit_if.sv
// Decode-stage to stack-pointer-unit bus: op request in, pointer/address/fault out.
interface stack_pointer_unit_if #(
    parameter int unsigned WIDTH = 32
);
    sp_pkg::sp_op_t      sp_op;
    logic [WIDTH-1:0]    write_data;
    logic                fault_clr;
    logic [WIDTH-1:0]    esp;
    logic [WIDTH-1:0]    mem_addr;
    logic                sp_fault;
    sp_pkg::fault_code_t fault_code;

    // Decode stage side: issues ops, observes pointer and faults.
    modport master (
        output sp_op, write_data, fault_clr,
        input  esp, mem_addr, sp_fault, fault_code
    );

    // Stack pointer unit side.
    modport slave (
        input  sp_op, write_data, fault_clr,
        output esp, mem_addr, sp_fault, fault_code
    );
endinterface

// File: rtl/stack_pointer_unit_guard.sv
// stack_guard: combinational legality check of the candidate pointer.
// Flags PUSH below LIMIT (or borrow), POP above TOP (or carry), and
// LOAD/ADJ/RESTORE results outside [LIMIT, TOP].
module stack_guard
    import sp_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] STEP  = 4,
    parameter logic [WIDTH-1:0] TOP   = 32'h000f_ffff,
    parameter logic [WIDTH-1:0] LIMIT = 32'h000e_0000
) (
    input  logic [WIDTH-1:0] candidate_i,
    input  sp_op_t           op_i,
    input  logic [WIDTH-1:0] esp_i,
    output logic             ok_o,
    output fault_code_t      code_o
);

    logic out_of_range;
    assign out_of_range = (candidate_i < LIMIT) || (candidate_i > TOP);

    // Classify the candidate; a wrapped subtraction/addition shows up as the
    // candidate moving the wrong way relative to esp.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        ok_o   = 1'b1;
        code_o = FC_NONE;
        case (op_i)
            SP_PUSH: begin
                if ((candidate_i > esp_i) || (candidate_i < LIMIT)) begin
                    ok_o   = 1'b0;
                    code_o = FC_OVF;
                end
            end
            SP_POP: begin
                if ((candidate_i < esp_i) || (candidate_i > TOP)) begin
                    ok_o   = 1'b0;
                    code_o = FC_UNF;
                end
            end
            SP_LOAD, SP_ADJ, SP_RESTORE: begin
                if (out_of_range) begin
                    ok_o   = 1'b0;
                    code_o = FC_RANGE;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit: single-cycle stack pointer register with shadow copy.
// Optional feature macro: STACK_GUARD_EN enables bounds checking with a
// sticky, first-fault-capturing fault flag; without it the pointer wraps
// freely and the fault outputs are tied low.
module stack_pointer_unit
    import sp_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] STEP  = 4,
    parameter logic [WIDTH-1:0] TOP   = 32'h000f_ffff,
    parameter logic [WIDTH-1:0] LIMIT = 32'h000e_0000
) (
    input  logic                 clock_5,
    input  logic                 reset,
    stack_pointer_unit_if.slave  bus
);

    logic [WIDTH-1:0] esp_q, esp_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             sp_fault_q, sp_fault_d;
    fault_code_t      fault_code_q, fault_code_d;
    logic [WIDTH-1:0] candidate;

    // Candidate next pointer for every esp-writing op, plus this cycle's access address.
    always_comb begin
        candidate = esp_q;
        case (bus.sp_op)
            SP_LOAD:    candidate = bus.write_data;
            SP_PUSH:    candidate = esp_q - STEP;
            SP_POP:     candidate = esp_q + STEP;
            SP_ADJ:     candidate = esp_q + bus.write_data;
            SP_RESTORE: candidate = shadow_q;
            default:    ;
        endcase
    end

    // PUSH pre-decrements, so it accesses the new slot; everything else uses esp.
    assign bus.mem_addr = (bus.sp_op == SP_PUSH) ? (esp_q - STEP) : esp_q;

    // SAVE copies the pointer as registered before this op.
    assign shadow_d = (bus.sp_op == SP_SAVE) ? esp_q : shadow_q;

`ifdef STACK_GUARD_EN
    logic        guard_ok;
    fault_code_t guard_code;

    stack_guard #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .TOP   (TOP),
        .LIMIT (LIMIT)
    ) u_guard (
        .candidate_i (candidate),
        .op_i        (bus.sp_op),
        .esp_i       (esp_q),
        .ok_o        (guard_ok),
        .code_o      (guard_code)
    );

    // Suppress illegal updates; a new fault beats fault_clr, and while a fault
    // is already pending the first code is kept.
    always_comb begin
        esp_d        = guard_ok ? candidate : esp_q;
        sp_fault_d   = sp_fault_q;
        fault_code_d = fault_code_q;
        if (!guard_ok) begin
            sp_fault_d = 1'b1;
            if (!sp_fault_q || bus.fault_clr) begin
                fault_code_d = guard_code;
            end
        end else if (bus.fault_clr) begin
            sp_fault_d   = 1'b0;
            fault_code_d = FC_NONE;
        end
    end
`else
    logic unused_fault_clr;
    assign unused_fault_clr = bus.fault_clr;

    // No checking: the pointer wraps modulo 2^WIDTH and faults never arise.
    always_comb begin
        esp_d        = candidate;
        sp_fault_d   = 1'b0;
        fault_code_d = FC_NONE;
    end
`endif

    // State registers with synchronous active-low reset; reset overrides any op.
    always_ff @(posedge clock_5) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset) begin
            esp_q        <= TOP;
            shadow_q     <= TOP;
            sp_fault_q   <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            esp_q        <= esp_d;
            shadow_q     <= shadow_d;
            sp_fault_q   <= sp_fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign bus.esp        = esp_q;
    assign bus.sp_fault   = sp_fault_q;
    assign bus.fault_code = fault_code_q;

endmodule
